// File: rtl/cpu_div_pkg.sv
// Shared types and constants for the EX-stage divider.
package cpu_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV_BY_ZERO,
        ON,
        END
    } div_state_t;

    localparam int DIV_CNT_W    = 6;
    localparam int DIV_ITER     = 32;
    localparam int DIV_RESULT_W = 64;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: trial-subtract the divisor from the shifted partial remainder.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W:0]   partial_rem,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] next_rem,
    output logic              quot_bit
);

    logic [DATA_W:0] diff;

    // The partial remainder is always below twice the divisor, so the top
    // bit of the difference is a reliable borrow/sign indicator.
    always_comb begin
        diff     = partial_rem - {1'b0, divisor};
        quot_bit = ~diff[DATA_W];
        next_rem = quot_bit ? diff[DATA_W-1:0] : partial_rem[DATA_W-1:0];
    end

endmodule

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider (DIV/DIVU) producing {remainder, quotient}.
// Optional divide-by-zero flag output enabled with DIV_ZERO_FLAG_EN.
module ex_div
    import cpu_div_pkg::*;
#(
    parameter int DATA_W = DIV_ITER
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                stall_o
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic                divzero_o
`endif
);

    localparam int                CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    div_state_t          state_q, state_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [DATA_W-1:0]   quo_q, quo_n;
    logic [DATA_W-1:0]   rem_q, rem_n;
    logic [DATA_W-1:0]   divisor_q, divisor_n;
    logic                signed_q, signed_n;
    logic                sign1_q, sign1_n;
    logic                sign2_q, sign2_n;
    logic                ready_n;
    logic [2*DATA_W-1:0] result_n;

    logic [DATA_W-1:0]   step_rem;
    logic                step_bit;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

`ifdef DIV_ZERO_FLAG_EN
    logic divzero_n;
`endif

    function automatic logic [DATA_W-1:0] abs_op(input logic [DATA_W-1:0] v, input logic s);
        return (s && v[DATA_W-1]) ? -v : v;
    endfunction

    // The quotient register starts out holding the dividend; its MSB feeds the
    // partial remainder while quotient bits fill in from the LSB.
    div_step #(
        .DATA_W(DATA_W)
    ) u_div_step (
        .partial_rem ({rem_q, quo_q[DATA_W-1]}),
        .divisor     (divisor_q),
        .next_rem    (step_rem),
        .quot_bit    (step_bit)
    );

    assign quo_fix = (signed_q && (sign1_q ^ sign2_q)) ? -quo_q : quo_q;
    assign rem_fix = (signed_q && sign1_q) ? -rem_q : rem_q;

    assign stall_o = start_i & ~ready_o;

    // NOTE: every signal assigned here gets a default first, otherwise paths
    // that skip an assignment would infer latches.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        quo_n     = quo_q;
        rem_n     = rem_q;
        divisor_n = divisor_q;
        signed_n  = signed_q;
        sign1_n   = sign1_q;
        sign2_n   = sign2_q;
        ready_n   = ready_o;
        result_n  = result_o;
`ifdef DIV_ZERO_FLAG_EN
        divzero_n = divzero_o;
`endif

        if (annul_i) begin
            state_n  = IDLE;
            cnt_n    = '0;
            ready_n  = 1'b0;
            result_n = '0;
`ifdef DIV_ZERO_FLAG_EN
            divzero_n = 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (opdata2_i == '0) begin
                            state_n = DIV_BY_ZERO;
                        end else begin
                            state_n   = ON;
                            cnt_n     = '0;
                            quo_n     = abs_op(opdata1_i, signed_div_i);
                            divisor_n = abs_op(opdata2_i, signed_div_i);
                            rem_n     = '0;
                            signed_n  = signed_div_i;
                            sign1_n   = opdata1_i[DATA_W-1];
                            sign2_n   = opdata2_i[DATA_W-1];
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    state_n  = END;
                    ready_n  = 1'b1;
                    result_n = '0;
`ifdef DIV_ZERO_FLAG_EN
                    divzero_n = 1'b1;
`endif
                end
                ON: begin
                    if (cnt_q == CNT_LAST) begin
                        state_n  = END;
                        ready_n  = 1'b1;
                        result_n = {rem_fix, quo_fix};
                    end else begin
                        rem_n = step_rem;
                        quo_n = {quo_q[DATA_W-2:0], step_bit};
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                END: begin
                    // Result is held while EX keeps start_i high during a stall.
                    if (!start_i) begin
                        state_n  = IDLE;
                        ready_n  = 1'b0;
                        result_n = '0;
`ifdef DIV_ZERO_FLAG_EN
                        divzero_n = 1'b0;
`endif
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            signed_q  <= 1'b0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            ready_o   <= 1'b0;
            result_o  <= '0;
`ifdef DIV_ZERO_FLAG_EN
            divzero_o <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            quo_q     <= quo_n;
            rem_q     <= rem_n;
            divisor_q <= divisor_n;
            signed_q  <= signed_n;
            sign1_q   <= sign1_n;
            sign2_q   <= sign2_n;
            ready_o   <= ready_n;
            result_o  <= result_n;
`ifdef DIV_ZERO_FLAG_EN
            divzero_o <= divzero_n;
`endif
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed corner cases plus random divides
// compared against a plain-arithmetic reference model.
module tb_ex_div;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;
`ifdef DIV_ZERO_FLAG_EN
    logic        divzero_o;
`endif

    int vectors     = 0;
    int miscompares = 0;

    ex_div #(
        .DATA_W(32)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stall_o      (stall_o)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .divzero_o    (divzero_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division on 64-bit integers, result kept modulo 2^32.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Start a divide, hold start until ready, keep it `hold` extra cycles, then release.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [63:0] exp, input int hold);
        int lat;
        int exp_lat;
        exp_lat = (b == 32'd0) ? 2 : 34;
        @(posedge clk_i); #1;
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        start_i      = 1'b1;
        lat = -1;
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk_i);
            if (ready_o === 1'b1) begin
                lat = n;
                break;
            end
            check({tag, "_stall"}, 64'(stall_o), 64'd1);
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, result_o, exp);
`ifdef DIV_ZERO_FLAG_EN
        check({tag, "_divzero"}, 64'(divzero_o), 64'(b == 32'd0));
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk_i);
            check({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
            check({tag, "_hold_result"}, result_o, exp);
        end
        @(posedge clk_i); #1;
        start_i   = 1'b0;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        @(negedge clk_i);
        check({tag, "_drop_ready"}, 64'(ready_o), 64'd1);
        check({tag, "_drop_stall"}, 64'(stall_o), 64'd0);
        @(negedge clk_i);
        check({tag, "_clear_ready"}, 64'(ready_o), 64'd0);
        check({tag, "_clear_result"}, result_o, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, b;
        logic        s;
        bit          saw_ready;

        rst_i        = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        repeat (3) @(negedge clk_i);
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("idle_stall", 64'(stall_o), 64'd0);

        do_div("divu_100_7", 32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, 0);
        do_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
        do_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 0);
        do_div("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000}, 0);
        do_div("divu_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0000_0000}, 0);
        do_div("div_by_zero", 32'h1234_5678, 32'd0, 1'b1, 64'd0, 0);

        // Flush in the middle of a divide: no result may appear.
        @(posedge clk_i); #1;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        repeat (11) @(posedge clk_i);
        #1 annul_i = 1'b1;
        @(posedge clk_i); #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        saw_ready = 1'b0;
        @(negedge clk_i);
        if (ready_o !== 1'b0) saw_ready = 1'b1;
        check("annul_no_ready", 64'(saw_ready), 64'd0);
        do_div("after_annul_9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 0);

        // Asynchronous reset while iterating, then while a result is presented.
        @(posedge clk_i); #1;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        repeat (15) @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check("rst_on_ready", 64'(ready_o), 64'd0);
        check("rst_on_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        do_div("after_rst_1000_3", 32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 0);

        @(posedge clk_i); #1;
        opdata1_i = 32'd50;
        opdata2_i = 32'd6;
        start_i   = 1'b1;
        repeat (36) @(posedge clk_i);
        #1;
        check("pre_rst_end_ready", 64'(ready_o), 64'd1);
        #1 rst_i = 1'b1;
        #1;
        check("rst_end_ready", 64'(ready_o), 64'd0);
        check("rst_end_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;

        do_div("hold_end_5", 32'hFFFF_FF9C, 32'd7, 1'b1, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 5);

        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = ~32'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            do_div($sformatf("rand_%0d", i), a, b, s, model(a, b, s), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
